decode_ctrl_pipe: RTL and testbench

- Registered, handshaked successor to the combinational control generator; sits between the IF/ID register and the execute stage.
- Decodes a 32-bit RV32 instruction into the control bundle plus register addresses, and holds the result in an ID/EX output register.
- Adds valid/ready flow control, flush, branch (beq) decode, illegal-instruction flagging, load-use bubble insertion and a stall counter.

---
 rtl/ctrl_pkg.sv | 32 +++
 rtl/ctrl_decode.sv | 92 +++++++++
 rtl/decode_ctrl_pipe.sv | 111 +++++++++++
 tb/tb_decode_ctrl_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the decode control pipeline.
//   - ALU operation codes (3-bit, zero-extended at the top level)
//   - RV32 major opcodes recognised by the decoder
//   - ctrl_t: packed control bundle produced by ctrl_decode
package ctrl_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_NOP = 3'b111;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       illegal;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational RV32 instruction decoder.
// Optional build macro: CTRL_MUL_EN enables decoding of MUL ({f7,f3}=0x008 on OP).
// Ports:
//   instr     in   32  instruction word
//   ctrl      out  ctrl_t control bundle (illegal encodings -> illegal=1, NOP)
//   used_rs1  out  1   instruction reads rs1
//   used_rs2  out  1   instruction reads rs2
//   rd/rs1/rs2 out 5   register address fields, passed through unconditionally
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        used_rs1,
    output logic        used_rs2,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [9:0] f73;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];
    assign f73    = {f7, f3};

    always_comb begin
        ctrl     = '0;
        ctrl.alu_op = ALU_NOP;
        used_rs1 = 1'b0;
        used_rs2 = 1'b0;
        // Start from illegal; each legal encoding clears it.
        ctrl.illegal = 1'b1;
        unique case (opcode)
            OP_IMM: begin
                if (f3 == 3'b000) begin
                    ctrl = '{alu_op: ALU_ADD, alu_src: 1'b1, reg_write: 1'b1, default: 1'b0};
                    used_rs1 = 1'b1;
                end else if (f3 == 3'b001 && f7 == 7'b0) begin
                    ctrl = '{alu_op: ALU_SLL, alu_src: 1'b1, reg_write: 1'b1, default: 1'b0};
                    used_rs1 = 1'b1;
                end
            end
            OP: begin
                unique case (f73)
                    10'h000: ctrl = '{alu_op: ALU_ADD, reg_write: 1'b1, default: 1'b0};
                    10'h100: ctrl = '{alu_op: ALU_SUB, reg_write: 1'b1, default: 1'b0};
                    10'h006: ctrl = '{alu_op: ALU_OR,  reg_write: 1'b1, default: 1'b0};
                    10'h007: ctrl = '{alu_op: ALU_AND, reg_write: 1'b1, default: 1'b0};
`ifdef CTRL_MUL_EN
                    10'h008: ctrl = '{alu_op: ALU_MUL, reg_write: 1'b1, default: 1'b0};
`endif
                    default: ;
                endcase
                if (!ctrl.illegal) begin
                    used_rs1 = 1'b1;
                    used_rs2 = 1'b1;
                end
            end
            LOAD: begin
                if (f3 == 3'b010) begin
                    ctrl = '{alu_op: ALU_ADD, mem_read: 1'b1, mem_to_reg: 1'b1,
                             alu_src: 1'b1, reg_write: 1'b1, default: 1'b0};
                    used_rs1 = 1'b1;
                end
            end
            STORE: begin
                if (f3 == 3'b010) begin
                    ctrl = '{alu_op: ALU_ADD, mem_write: 1'b1, alu_src: 1'b1, default: 1'b0};
                    used_rs1 = 1'b1;
                    used_rs2 = 1'b1;
                end
            end
            BRANCH: begin
                if (f3 == 3'b000) begin
                    ctrl = '{alu_op: ALU_SUB, branch: 1'b1, default: 1'b0};
                    used_rs1 = 1'b1;
                    used_rs2 = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered, handshaked RV32 control decode stage (ID/EX register).
// Optional build macro: CTRL_MUL_EN (passed through to ctrl_decode; enables MUL decode).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush                      squash decode input and output register
//   in_valid/in_ready/in_instr upstream handshake + instruction
//   out_valid/out_ready        downstream handshake
//   out_branch..out_reg_write  registered control bits
//   out_alu_op [ALUOP_W]       ALU op, zero-extended 3-bit code
//   out_illegal                undecodable instruction (still emitted as valid)
//   out_rd/out_rs1/out_rs2     register addresses
//   stall_count [STALL_CNT_W]  saturating count of load-use bubbles
module decode_ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_branch,
    output logic                   out_mem_read,
    output logic                   out_mem_to_reg,
    output logic                   out_mem_write,
    output logic                   out_alu_src,
    output logic                   out_reg_write,
    output logic [ALUOP_W-1:0]     out_alu_op,
    output logic                   out_illegal,
    output logic [REG_ADDR_W-1:0]  out_rd,
    output logic [REG_ADDR_W-1:0]  out_rs1,
    output logic [REG_ADDR_W-1:0]  out_rs2,
    output logic [STALL_CNT_W-1:0] stall_count
);

    ctrl_t                 dec;
    logic                  used_rs1;
    logic                  used_rs2;
    logic [4:0]            dec_rd5, dec_rs1_5, dec_rs2_5;
    logic [REG_ADDR_W-1:0] dec_rd, dec_rs1, dec_rs2;
    logic                  hazard;
    logic                  accept;

    ctrl_decode u_dec (
        .instr    (in_instr),
        .ctrl     (dec),
        .used_rs1 (used_rs1),
        .used_rs2 (used_rs2),
        .rd       (dec_rd5),
        .rs1      (dec_rs1_5),
        .rs2      (dec_rs2_5)
    );

    assign dec_rd  = REG_ADDR_W'(dec_rd5);
    assign dec_rs1 = REG_ADDR_W'(dec_rs1_5);
    assign dec_rs2 = REG_ADDR_W'(dec_rs2_5);

    // Load in the output register whose result the incoming instruction needs.
    assign hazard = out_valid & out_mem_read & (out_rd != '0) & in_valid &
                    ((used_rs1 & (dec_rs1 == out_rd)) | (used_rs2 & (dec_rs2 == out_rd)));

    // Gated by rst_n so upstream never sees a handshake while the stage is in reset.
    assign in_ready = rst_n & (flush | ((~out_valid | out_ready) & ~hazard));
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_branch     <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_mem_write  <= 1'b0;
            out_alu_src    <= 1'b0;
            out_reg_write  <= 1'b0;
            out_alu_op     <= ALUOP_W'(ALU_NOP);
            out_illegal    <= 1'b0;
            out_rd         <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            stall_count    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_branch     <= dec.branch;
            out_mem_read   <= dec.mem_read;
            out_mem_to_reg <= dec.mem_to_reg;
            out_mem_write  <= dec.mem_write;
            out_alu_src    <= dec.alu_src;
            out_reg_write  <= dec.reg_write;
            out_alu_op     <= ALUOP_W'(dec.alu_op);
            out_illegal    <= dec.illegal;
            out_rd         <= dec_rd;
            out_rs1        <= dec_rs1;
            out_rs2        <= dec_rs2;
        end else if (out_ready & hazard) begin
            out_valid <= 1'b0;
            if (stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
module tb_decode_ctrl_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic        out_branch, out_mem_read, out_mem_to_reg, out_mem_write;
    logic        out_alu_src, out_reg_write, out_illegal;
    logic [2:0]  out_alu_op;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [15:0] stall_count;

    int checks = 0;
    int fails  = 0;

    decode_ctrl_pipe #(.ALUOP_W(3), .REG_ADDR_W(5), .STALL_CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_branch     (out_branch),
        .out_mem_read   (out_mem_read),
        .out_mem_to_reg (out_mem_to_reg),
        .out_mem_write  (out_mem_write),
        .out_alu_src    (out_alu_src),
        .out_reg_write  (out_reg_write),
        .out_alu_op     (out_alu_op),
        .out_illegal    (out_illegal),
        .out_rd         (out_rd),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pack {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, illegal, alu_op}
    function automatic logic [9:0] ctl();
        return {out_branch, out_mem_read, out_mem_to_reg, out_mem_write,
                out_alu_src, out_reg_write, out_illegal, out_alu_op};
    endfunction

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ctl", {22'b0, ctl()}, {22'b0, 10'b0000000_111});
        chk("rst_stall", {16'b0, stall_count}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);

        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00500093;              // addi x1,x0,5
        #1;
        chk("addi_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("addi_valid", {31'b0, out_valid}, 32'd1);
        chk("addi_ctl", {22'b0, ctl()}, {22'b0, 10'b0000110_000});
        chk("addi_rd", {27'b0, out_rd}, 32'd1);

        in_instr = 32'h00108133;               // add x2,x1,x1
        #1;
        chk("add_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add_ctl", {22'b0, ctl()}, {22'b0, 10'b0000010_000});
        chk("add_regs", {17'b0, out_rd, out_rs1, out_rs2}, {17'b0, 5'd2, 5'd1, 5'd1});

        in_instr = 32'h0000A183;               // lw x3,0(x1)
        step();
        chk("lw_ctl", {22'b0, ctl()}, {22'b0, 10'b0110110_000});
        chk("lw_rd", {27'b0, out_rd}, 32'd3);
        in_instr = 32'h00218233;               // add x4,x3,x2 -> load-use
        #1;
        chk("hz_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        chk("hz_bubble", {31'b0, out_valid}, 32'd0);
        chk("hz_stall", {16'b0, stall_count}, 32'd1);
        chk("hz_in_ready_after", {31'b0, in_ready}, 32'd1);
        step();
        chk("hz_add_valid", {31'b0, out_valid}, 32'd1);
        chk("hz_add_rd", {27'b0, out_rd}, 32'd4);

        in_instr = 32'h0000A003;               // lw x0,0(x1)
        step();
        chk("lw0_valid", {31'b0, out_valid}, 32'd1);
        in_instr = 32'h00200233;               // add x4,x0,x2
        #1;
        chk("lw0_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("lw0_add_valid", {31'b0, out_valid}, 32'd1);
        chk("lw0_add_ctl", {22'b0, ctl()}, {22'b0, 10'b0000010_000});
        chk("lw0_stall", {16'b0, stall_count}, 32'd1);

        in_instr = 32'h00208063;               // beq x1,x2,0
        step();
        out_ready = 1'b0;
        in_instr  = 32'h0020A023;              // sw x2,0(x1)
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_beq_ctl", {22'b0, ctl()}, {22'b0, 10'b1000000_001});
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("sw_valid", {31'b0, out_valid}, 32'd1);
        chk("sw_ctl", {22'b0, ctl()}, {22'b0, 10'b0001100_000});
        chk("sw_rs2", {27'b0, out_rs2}, 32'd2);

        flush    = 1'b1;
        in_instr = 32'h00309293;               // slli x5,x1,3 (dropped)
        #1;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        flush = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_stall", {16'b0, stall_count}, 32'd1);
        step();
        chk("slli_valid", {31'b0, out_valid}, 32'd1);
        chk("slli_ctl", {22'b0, ctl()}, {22'b0, 10'b0000110_101});
        chk("slli_rd", {27'b0, out_rd}, 32'd5);

        in_instr = 32'hFFFFFFFF;               // undecodable opcode
        step();
        chk("ill_valid", {31'b0, out_valid}, 32'd1);
        chk("ill_ctl", {22'b0, ctl()}, {22'b0, 10'b0000001_111});
        chk("ill_rd", {27'b0, out_rd}, 32'd31);

        in_instr = 32'h02208033;               // mul x0,x1,x2
        step();
`ifdef CTRL_MUL_EN
        chk("mul_ctl", {22'b0, ctl()}, {22'b0, 10'b0000010_100});
`else
        chk("mul_ctl", {22'b0, ctl()}, {22'b0, 10'b0000001_111});
`endif

        in_valid = 1'b0;
        step();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        in_valid = 1'b1;
        in_instr = 32'h00500093;
        step();
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_ctl", {22'b0, ctl()}, {22'b0, 10'b0000000_111});
        chk("async_rst_rd", {27'b0, out_rd}, 32'd0);
        chk("async_rst_stall", {16'b0, stall_count}, 32'd0);
        chk("async_rst_in_ready", {31'b0, in_ready}, 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
